// File: rtl/adc_multi_sampler_if.sv
// rtl/adc_multi_sampler_if.sv - frame output valid/ready bundle for adc_multi_sampler
interface adc_multi_sampler_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 4
);
  logic [NUM_CH*DATA_WIDTH-1:0] data;
  logic                         valid;
  logic                         ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/adc_multi_sampler.sv
// rtl/adc_multi_sampler.sv - multi-channel ADC conversion strobe, SCK and deserialiser
// Optional test-pattern frame source: ADC_MULTI_SAMPLER_TEST_PATTERN_EN.
module adc_multi_sampler #(
  parameter int DATA_WIDTH    = 16,
  parameter int NUM_CH        = 4,
  parameter int CLK_DIV       = 2,
  parameter int T_CONV_CYCLES = 40,
  parameter int PERIOD_WIDTH  = 16
) (
  input  logic                    clk_adc,
  input  logic                    rst_n,
  input  logic                    trig_i,
  input  logic                    auto_en_i,
  input  logic [PERIOD_WIDTH-1:0] period_i,
  input  logic                    overrun_clr_i,
  input  logic [NUM_CH-1:0]       adc_miso_i,
`ifdef ADC_MULTI_SAMPLER_TEST_PATTERN_EN
  input  logic                    test_mode_i,
`endif
  output logic                    adc_cnv_n_o,
  output logic                    adc_sck_o,
  output logic                    busy_o,
  output logic                    overrun_o,
  adc_multi_sampler_if.master     frame_if
);
  localparam int CONV_W = (T_CONV_CYCLES > 1) ? $clog2(T_CONV_CYCLES) : 1;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W  = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_CONV, S_GAP, S_READ, S_DONE} state_t;

  state_t                            r_state;
  logic                              r_trig_s1, r_trig_s2, r_req;
  logic [PERIOD_WIDTH-1:0]           r_timer;
  logic [CONV_W-1:0]                 r_conv_cnt;
  logic [DIV_W-1:0]                  r_div;
  logic [BIT_W-1:0]                  r_bit;
  logic                              r_cnv_n, r_sck, r_busy, r_valid, r_ovr;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] r_shift, r_data;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] w_frame;
  logic                              w_sw_req, w_auto_req, w_load, w_ovr_set;

  assign w_sw_req   = r_trig_s1 & ~r_trig_s2;
  // >= keeps the timer from running through the full range when period_i shrinks
  assign w_auto_req = auto_en_i && (r_timer >= period_i);
  assign w_load     = (r_state == S_DONE) && (!r_valid || frame_if.ready);
  assign w_ovr_set  = (r_req && r_state != S_IDLE) || ((r_state == S_DONE) && !w_load);

  always_ff @(posedge clk_adc or negedge rst_n) begin
    if (!rst_n) begin
      r_trig_s1 <= 1'b0;
      r_trig_s2 <= 1'b0;
      r_req     <= 1'b0;
      r_timer   <= '0;
    end else begin
      r_trig_s1 <= trig_i;
      r_trig_s2 <= r_trig_s1;
      r_req     <= w_sw_req | w_auto_req;
      if (!auto_en_i || w_auto_req) r_timer <= '0;
      else                          r_timer <= r_timer + 1'b1;
    end
  end

`ifdef ADC_MULTI_SAMPLER_TEST_PATTERN_EN
  logic [DATA_WIDTH-1:0] r_frame_cnt;

  always_ff @(posedge clk_adc or negedge rst_n) begin
    if (!rst_n)                 r_frame_cnt <= '0;
    else if (r_state == S_DONE) r_frame_cnt <= r_frame_cnt + 1'b1;
  end

  always_comb begin
    w_frame = r_shift;
    if (test_mode_i)
      for (int c = 0; c < NUM_CH; c++) w_frame[c] = r_frame_cnt + DATA_WIDTH'(c);
  end
`else
  assign w_frame = r_shift;
`endif

  always_ff @(posedge clk_adc or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnv_n    <= 1'b1;
      r_sck      <= 1'b0;
      r_busy     <= 1'b0;
      r_conv_cnt <= '0;
      r_div      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      if (w_ovr_set)          r_ovr <= 1'b1;
      else if (overrun_clr_i) r_ovr <= 1'b0;
      if (frame_if.ready) r_valid <= 1'b0;
      if (w_load) begin
        r_valid <= 1'b1;
        r_data  <= w_frame;
      end
      case (r_state)
        S_IDLE: if (r_req) begin
          r_state    <= S_CONV;
          r_cnv_n    <= 1'b0;
          r_busy     <= 1'b1;
          r_conv_cnt <= '0;
        end
        S_CONV: if (r_conv_cnt == CONV_W'(T_CONV_CYCLES - 1)) begin
          r_state <= S_GAP;
          r_cnv_n <= 1'b1;
        end else begin
          r_conv_cnt <= r_conv_cnt + 1'b1;
        end
        S_GAP: begin
          r_state <= S_READ;
          r_div   <= '0;
          r_bit   <= '0;
        end
        // Each bit: CLK_DIV cycles low, CLK_DIV high; sample on the rising SCK edge
        S_READ: if (r_div == DIV_W'(CLK_DIV - 1)) begin
          r_div <= '0;
          r_sck <= ~r_sck;
          if (!r_sck) begin
            for (int c = 0; c < NUM_CH; c++)
              r_shift[c] <= {r_shift[c][DATA_WIDTH-2:0], adc_miso_i[c]};
          end else if (r_bit == BIT_W'(DATA_WIDTH - 1)) begin
            r_state <= S_DONE;
          end else begin
            r_bit <= r_bit + 1'b1;
          end
        end else begin
          r_div <= r_div + 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign adc_cnv_n_o    = r_cnv_n;
  assign adc_sck_o      = r_sck;
  assign busy_o         = r_busy;
  assign overrun_o      = r_ovr;
  assign frame_if.data  = r_data;
  assign frame_if.valid = r_valid;
endmodule
